// File: rtl/main_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : main_pkg                                                |
// | Description : Shared widths, FSM state type and address-field helpers |
// |               for the direct-mapped read-only cache model.            |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
package main_pkg;

  localparam int ADDR_W          = 32;
  localparam int DATA_W          = 32;
  localparam int NUM_LINES       = 256;
  localparam int WORDS_PER_BLOCK = 4;

  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int WSEL_W = $clog2(WORDS_PER_BLOCK);
  localparam int TAG_W  = ADDR_W - IDX_W - WSEL_W - 2;
  // Block address = tag concatenated with index (word-select and byte bits dropped)
  localparam int BLK_W  = TAG_W + IDX_W;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;

  function automatic logic [TAG_W-1:0] get_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [IDX_W-1:0] get_index(input logic [ADDR_W-1:0] addr);
    return addr[2+WSEL_W +: IDX_W];
  endfunction

  function automatic logic [WSEL_W-1:0] get_wsel(input logic [ADDR_W-1:0] addr);
    return addr[2 +: WSEL_W];
  endfunction

  // Synthetic memory contents: every word holds its own word-aligned address
  function automatic logic [DATA_W-1:0] backing_word(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/cache_backing_mem.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : cache_backing_mem                                       |
// | Description : Combinational synthetic backing store. Kept separate so |
// |               a real memory can replace it without touching the cache.|
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module cache_backing_mem
  import main_pkg::*;
(
  input  logic [BLK_W-1:0]  block_addr_i,
  input  logic [WSEL_W-1:0] wsel_i,
  output logic [DATA_W-1:0] data_o
);

  assign data_o = backing_word({block_addr_i, wsel_i, 2'b00});

endmodule
`default_nettype wire

// File: rtl/main.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : main                                                    |
// | Description : Direct-mapped read-only cache with a synthetic backing  |
// |               memory. Combinational hit/data, two-state miss FSM that |
// |               fills a whole block after MISS_LATENCY cycles.          |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module main
  import main_pkg::*;
#(
  parameter int MISS_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] address,
  output logic              hit,
  output logic [DATA_W-1:0] dataOut
);

  localparam int                CNT_W    = (MISS_LATENCY > 1) ? $clog2(MISS_LATENCY) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MISS_LATENCY - 1);

  // Miss FSM state; `read` is probed by name from the evaluation harness
  state_e             state_q;
  logic               read;
  logic [CNT_W-1:0]   cnt_q;
  logic [TAG_W-1:0]   fill_tag_q;
  logic [IDX_W-1:0]   fill_index_q;

  // Line storage: only valid bits carry reset, tags/data are don't-care until valid
  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [DATA_W-1:0]    data_q [NUM_LINES][WORDS_PER_BLOCK];

  logic [TAG_W-1:0]   cur_tag;
  logic [IDX_W-1:0]   cur_index;
  logic [WSEL_W-1:0]  cur_wsel;
  logic               fill_done;
  logic [DATA_W-1:0]  fill_words [WORDS_PER_BLOCK];

  assign cur_tag   = get_tag(address);
  assign cur_index = get_index(address);
  assign cur_wsel  = get_wsel(address);

  // Last FILL cycle: the line is written on this edge
  assign fill_done = (state_q == FILL) && (cnt_q == CNT_LAST);

  // One backing-memory port per word so the whole block is written in one edge
  generate
    for (genvar w = 0; w < WORDS_PER_BLOCK; w++) begin : g_fill_word
      cache_backing_mem u_mem (
        .block_addr_i ({fill_tag_q, fill_index_q}),
        .wsel_i       (WSEL_W'(w)),
        .data_o       (fill_words[w])
      );
    end
  endgenerate

  // Hit only while idle so a line being filled or a stale match never leaks out
  assign hit     = (state_q == IDLE) && valid_q[cur_index] && (tag_q[cur_index] == cur_tag);
  assign dataOut = hit ? data_q[cur_index][cur_wsel] : '0;

  // Miss FSM: latch the missing line, wait MISS_LATENCY cycles, then return to IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      read         <= 1'b0;
      cnt_q        <= '0;
      fill_tag_q   <= '0;
      fill_index_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!hit) begin
            state_q      <= FILL;
            read         <= 1'b1;
            cnt_q        <= '0;
            fill_tag_q   <= cur_tag;
            fill_index_q <= cur_index;
          end
        end
        FILL: begin
          if (cnt_q == CNT_LAST) begin
            state_q <= IDLE;
            read    <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          read    <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Valid bits: cleared by reset, so a fill aborted by reset leaves the line invalid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (fill_done) begin
      valid_q[fill_index_q] <= 1'b1;
    end
  end

  // Tag and data install; a conflicting line is simply overwritten (read-only cache)
  always_ff @(posedge clk) begin
    if (fill_done) begin
      tag_q[fill_index_q] <= fill_tag_q;
      for (int w = 0; w < WORDS_PER_BLOCK; w++) begin
        data_q[fill_index_q][w] <= fill_words[w];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_main.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_main                                                 |
// | Description : Self-checking bench for the direct-mapped cache: directed|
// |               miss/hit/conflict/reset steps, then a random trace      |
// |               replay against a behavioural cache model.               |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module tb_main;

  localparam int ML = 1;

  logic        clk;
  logic        rst_n;
  logic [31:0] address;
  logic        hit;
  logic [31:0] dataOut;

  int checks = 0;
  int errors = 0;

  main #(.MISS_LATENCY(ML)) uut (
    .clk     (clk),
    .rst_n   (rst_n),
    .address (address),
    .hit     (hit),
    .dataOut (dataOut)
  );

  initial clk = 1'b0;
  always #2 clk = ~clk;

  // Behavioural cache model: resident lines and a busy timer for an outstanding fill
  bit          m_valid [256];
  bit   [19:0] m_tag   [256];
  int          m_busy;
  bit   [19:0] m_ftag;
  bit   [7:0]  m_fidx;
  int          m_misses;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic bit m_resident(input logic [31:0] a);
    return m_valid[a[11:4]] && (m_tag[a[11:4]] == a[31:12]);
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [19:0] t;
    logic [7:0]  ix;
    logic [3:0]  lo;
    t  = 20'($urandom_range(0, 3));
    if (t == 20'd3) t = 20'hFFFFF;
    ix = 8'($urandom_range(0, 7));
    lo = 4'($urandom_range(0, 15));
    return {t, ix, lo};
  endfunction

  // Hard time limit so the bench always ends
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  dut_miss;
    bit  prev_read;

    rst_n   = 1'b0;
    address = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hit",  {31'b0, hit}, 32'h0);
    check("reset_data", dataOut, 32'h0);
    check("reset_read", {31'b0, uut.read}, 32'h0);

    // Cold miss on 0x40: hit low across the detect and fill edges
    rst_n   = 1'b1;
    address = 32'h0000_0040;
    #1;
    check("cold_hit_pre", {31'b0, hit}, 32'h0);
    @(posedge clk); #1;
    check("cold_hit_e1",  {31'b0, hit}, 32'h0);
    check("cold_read_e1", {31'b0, uut.read}, 32'h1);
    @(posedge clk); #1;
    check("cold_hit_e2",  {31'b0, hit}, 32'h1);
    check("cold_data_e2", dataOut, 32'h0000_0040);
    check("cold_read_e2", {31'b0, uut.read}, 32'h0);

    // Same line, other word: immediate hit, no fill
    address = 32'h0000_004C;
    #1;
    check("word_hit",  {31'b0, hit}, 32'h1);
    check("word_data", dataOut, 32'h0000_004C);
    @(posedge clk); #1;
    check("word_read", {31'b0, uut.read}, 32'h0);
    check("word_hit2", {31'b0, hit}, 32'h1);

    // Conflict on index 4: 0x1040 evicts 0x40, then 0x40 misses again
    address = 32'h0000_1040;
    #1;
    check("conf_hit_pre", {31'b0, hit}, 32'h0);
    @(posedge clk); #1;
    check("conf_read", {31'b0, uut.read}, 32'h1);
    @(posedge clk); #1;
    check("conf_hit",  {31'b0, hit}, 32'h1);
    check("conf_data", dataOut, 32'h0000_1040);
    address = 32'h0000_0040;
    #1;
    check("evict_hit", {31'b0, hit}, 32'h0);
    @(posedge clk); #1;
    check("evict_read", {31'b0, uut.read}, 32'h1);
    @(posedge clk); #1;
    check("refill_hit",  {31'b0, hit}, 32'h1);
    check("refill_data", dataOut, 32'h0000_0040);

    // Address moves to a resident line during a fill: hit stays low until fill ends
    address = 32'h0000_2080;
    #1;
    check("mid_hit_pre", {31'b0, hit}, 32'h0);
    @(posedge clk); #1;
    check("mid_read", {31'b0, uut.read}, 32'h1);
    address = 32'h0000_0040;
    #1;
    check("mid_hit_fill", {31'b0, hit}, 32'h0);
    @(posedge clk); #1;
    check("mid_hit_after",  {31'b0, hit}, 32'h1);
    check("mid_data_after", dataOut, 32'h0000_0040);
    address = 32'h0000_2080;
    #1;
    check("mid_line8_hit",  {31'b0, hit}, 32'h1);
    check("mid_line8_data", dataOut, 32'h0000_2080);

    // Reset during a fill aborts it and invalidates everything
    address = 32'h0000_3040;
    #1;
    @(posedge clk); #1;
    check("rst_fill_read", {31'b0, uut.read}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_hit",  {31'b0, hit}, 32'h0);
    check("rst_mid_data", dataOut, 32'h0);
    check("rst_mid_read", {31'b0, uut.read}, 32'h0);
    address = 32'h0000_2080;
    rst_n   = 1'b1;
    #1;
    check("rst_lost_hit", {31'b0, hit}, 32'h0);
    @(posedge clk); #1;
    check("rst_lost_read", {31'b0, uut.read}, 32'h1);
    @(posedge clk); #1;
    check("rst_refill_hit", {31'b0, hit}, 32'h1);
    address = 32'h0000_3040;
    #1;
    check("rst_abort_hit", {31'b0, hit}, 32'h0);

    // Random trace replay: new address every 10 time units, model tracks fills
    rst_n = 1'b0;
    for (int i = 0; i < 256; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 20'h0;
    end
    m_busy    = 0;
    m_misses  = 0;
    dut_miss  = 0;
    prev_read = 1'b0;
    @(posedge clk);
    fork
      begin
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 1000; i++) begin
          address = rand_addr();
          #10;
        end
      end
      begin
        repeat (2500) begin
          @(posedge clk);
          if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
              m_valid[m_fidx] = 1'b1;
              m_tag[m_fidx]   = m_ftag;
            end
          end else if (!m_resident(address)) begin
            m_misses++;
            m_ftag = address[31:12];
            m_fidx = address[11:4];
            m_busy = ML;
          end
          @(negedge clk);
          begin
            bit          e_hit;
            logic [31:0] e_data;
            e_hit  = (m_busy == 0) && m_resident(address);
            e_data = e_hit ? {address[31:2], 2'b00} : 32'h0;
            check("trace_hit",  {31'b0, hit}, {31'b0, e_hit});
            check("trace_data", dataOut, e_data);
            check("trace_read", {31'b0, uut.read}, {31'b0, (m_busy > 0)});
          end
          if (uut.read && !prev_read) dut_miss++;
          prev_read = uut.read;
        end
      end
    join
    check("trace_miss_count", dut_miss, m_misses);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
